// File: rtl/vga_char_fetch_pkg.sv
// vga_char_fetch_pkg: shared text-mode geometry, timing defaults and text word layout
package vga_char_fetch_pkg;
  localparam int CHAR_W   = 10;
  localparam int FONT_H   = 16;
  localparam int FONT_W   = 8;
  localparam int CHAR_LSB = 0;
  localparam int ATTR_LSB = 8;
  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_TOTAL      = 800;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_TOTAL      = 525;
  localparam int DEF_COLS         = 64;
  localparam int DEF_ADDR_W       = 11;
  localparam int DEF_BLINK_FRAMES = 16;
  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } txt_word_t;
  function automatic logic [9:0] next_line(input logic [9:0] v, input int v_total);
    return (v == 10'(v_total - 1)) ? '0 : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_cursor_blink.sv
// vga_cursor_blink: counts frames and toggles the cursor blink phase every BLINK_FRAMES frames
module vga_cursor_blink #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_h,
  input  logic [10:0] i_hcnt,
  input  logic [9:0]  i_vcnt,
  output logic        o_blink
);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame;
  logic          frame_end, wrap;
  assign frame_end = (i_vcnt == 10'(V_TOTAL - 1)) && (i_hcnt == 11'(H_TOTAL - 1));
  assign wrap = frame == FW'(BLINK_FRAMES - 1);
  always_ff @(posedge i_clk)
    if (i_rst_h) begin
      frame   <= '0;
      o_blink <= 1'b0;
    end else if (frame_end) begin
      frame   <= wrap ? '0 : frame + FW'(1);
      o_blink <= o_blink ^ wrap;
    end
endmodule

// File: rtl/vga_char_fetch.sv
// vga_char_fetch: prefetches text/font data per 10-pixel cell and feeds the pixel shift register
module vga_char_fetch
  import vga_char_fetch_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int COLS         = DEF_COLS,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic              i_clk,
  input  logic              i_rst_h,
  input  logic [10:0]       i_hcnt,
  input  logic [9:0]        i_vcnt,
  output logic [ADDR_W-1:0] o_txt_addr,
  input  logic [15:0]       i_txt_data,
  output logic [11:0]       o_font_addr,
  input  logic [7:0]        i_font_data,
  input  logic [ADDR_W-1:0] i_cur_addr,
  input  logic              i_cur_en_h,
  output logic [7:0]        o_data,
  output logic              o_ld_h,
  output logic              o_cs_h,
  output logic [7:0]        o_attr
);
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(COLS * (V_ACTIVE / FONT_H));
  logic [3:0]        ph, cur_p, font_row;
  logic [CW-1:0]     col, cur_k;
  logic              fetch_active, start, run, last, l_act, cur_hit, blink, on_screen;
  logic [9:0]        fetch_l;
  logic [ADDR_W-1:0] row_base, rb_nxt;
  logic [7:0]        attr_pend, font_q;
  txt_word_t         tw;
  vga_cursor_blink #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .i_clk(i_clk),
    .i_rst_h(i_rst_h),
    .i_hcnt(i_hcnt),
    .i_vcnt(i_vcnt),
    .o_blink(blink)
  );
  assign tw = i_txt_data;
  // the prefetch start doubles as phase 0 of slot 0, so it resyncs any running fetch
  always_comb begin
    start     = i_hcnt == 11'(H_TOTAL - CHAR_W);
    fetch_l   = next_line(i_vcnt, V_TOTAL);
    l_act     = fetch_l < 10'(V_ACTIVE);
    rb_nxt    = (fetch_l == '0) ? '0 : (fetch_l[3:0] == 4'd0) ? row_base + ADDR_W'(COLS) : row_base;
    run       = start ? l_act : fetch_active;
    cur_p     = start ? 4'd0 : ph;
    cur_k     = start ? '0 : col;
    last      = (cur_p == 4'(CHAR_W - 1)) && (cur_k == CW'(COLS - 1));
    on_screen = {1'b0, i_cur_addr} < CELLS;
  end
  always_ff @(posedge i_clk)
    if (i_rst_h) begin
      ph           <= '0;
      col          <= '0;
      fetch_active <= 1'b0;
      row_base     <= '0;
      font_row     <= '0;
      attr_pend    <= '0;
      font_q       <= '0;
      cur_hit      <= 1'b0;
      o_txt_addr   <= '0;
      o_font_addr  <= '0;
      o_data       <= '0;
      o_ld_h       <= 1'b0;
      o_cs_h       <= 1'b0;
      o_attr       <= '0;
    end else begin
      if (start) begin
        row_base <= rb_nxt;
        font_row <= fetch_l[3:0];
      end
      fetch_active <= run && !last;
      if (run) begin
        ph  <= (cur_p == 4'(CHAR_W - 1)) ? 4'd0 : cur_p + 4'd1;
        col <= (cur_p == 4'(CHAR_W - 1)) ? cur_k + CW'(1) : cur_k;
        if (cur_p == 4'd0) o_txt_addr <= (start ? rb_nxt : row_base) + ADDR_W'(cur_k);
        if (cur_p == 4'd2) begin
          o_font_addr <= {tw.chr, font_row};
          attr_pend   <= tw.attr;
          cur_hit     <= i_cur_en_h && (o_txt_addr == i_cur_addr) && on_screen &&
                         (font_row >= 4'(FONT_H - 2)) && blink;
        end
        if (cur_p == 4'd4) font_q <= cur_hit ? 8'hFF : i_font_data;
        if (cur_p == 4'd8) begin
          o_data <= font_q;
          o_ld_h <= 1'b1;
        end
        if (cur_p == 4'd9) begin
          o_ld_h <= 1'b0;
          o_attr <= attr_pend;
        end
      end
      if (i_hcnt == 11'(H_ACTIVE - 1)) o_cs_h <= 1'b0;
      else if (run && cur_p == 4'd8 && cur_k == '0) o_cs_h <= 1'b1;
    end
endmodule

// File: tb/tb_vga_char_fetch.sv
// tb_vga_char_fetch: randomized text/font contents checked against a timeline model of the fetch
module tb_vga_char_fetch;
  logic        clk = 0, rst = 1, cur_en = 0, ld, cs;
  logic [10:0] hcnt = 780, txt_addr, cur_addr = 0;
  logic [9:0]  vcnt = 524;
  logic [15:0] txt_data = 0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = 0, data, attr;
  logic [15:0] txt_mem [2048];
  logic [7:0]  font_mem [4096];
  int n_cmp = 0, n_bad = 0, stage = 0, ld_cnt = 0, ib_cnt = 0;
  bit chk_en = 0;
  vga_char_fetch dut (
    .i_clk(clk), .i_rst_h(rst), .i_hcnt(hcnt), .i_vcnt(vcnt),
    .o_txt_addr(txt_addr), .i_txt_data(txt_data), .o_font_addr(font_addr), .i_font_data(font_data),
    .i_cur_addr(cur_addr), .i_cur_en_h(cur_en), .o_data(data), .o_ld_h(ld), .o_cs_h(cs), .o_attr(attr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    txt_data  <= txt_mem[txt_addr];
    font_data <= font_mem[font_addr];
  end
  // model: t counts cycles since the prefetch start; slot k = t/10, phase = t%10
  int m_t, m_rb, m_ev, ml, mk;
  bit m_run;
  logic [3:0]  m_row;
  logic        m_hit, e_ld, e_cs;
  logic [10:0] e_addr, ma;
  logic [11:0] e_font;
  logic [7:0]  e_data, e_attr;
  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_t = 0; m_rb = 0; m_ev = 0; m_row = 0; m_hit = 0;
      e_addr = 0; e_font = 0; e_data = 0; e_attr = 0; e_ld = 0; e_cs = 0;
    end else begin
      e_ld = 0;
      if (vcnt == 524 && hcnt == 799) m_ev++;
      if (hcnt == 639) e_cs = 0;
      if (hcnt == 790) begin
        ml = (vcnt == 524) ? 0 : vcnt + 1;
        m_rb = (ml == 0) ? 0 : (ml % 16 == 0) ? m_rb + 64 : m_rb;
        m_row = 4'(ml % 16);
        m_run = ml < 480;
        m_t = 0;
      end else if (m_run) begin
        m_t++;
        if (m_t == 640) m_run = 0;
      end
      if (m_run) begin
        mk = m_t / 10;
        ma = 11'(m_rb + mk);
        case (m_t % 10)
          0: e_addr = ma;
          2: begin
            e_font = {txt_mem[ma][7:0], m_row};
            m_hit = cur_en && cur_addr == ma && m_row >= 14 && (m_ev / 16) % 2 == 1;
          end
          8: begin
            e_data = m_hit ? 8'hFF : font_mem[e_font];
            e_ld = 1;
            if (mk == 0) e_cs = 1;
          end
          9: e_attr = txt_mem[ma][15:8];
          default: ;
        endcase
      end
    end
  end
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at v=%0d h=%0d stage=%0d", n, a, e, vcnt, hcnt, stage);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("txt_addr", txt_addr, e_addr);
    chk("font_addr", font_addr, e_font);
    chk("data", data, e_data);
    chk("ld", ld, e_ld);
    chk("cs", cs, e_cs);
    chk("attr", attr, e_attr);
    if (stage == 1 && ld && ((vcnt == 524 && hcnt >= 790) || (vcnt == 0 && hcnt < 790))) ld_cnt++;
    if (stage == 5 && vcnt >= 480 && vcnt <= 523 && (ld || cs)) ib_cnt++;
    if (stage == 1 && vcnt == 524 && hcnt == 791) chk("lit_first_addr", txt_addr, 0);
    if (stage == 1 && vcnt == 524 && hcnt == 798) chk("lit_ld_early", ld, 0);
    if (stage == 1 && vcnt == 524 && hcnt == 799) begin
      chk("lit_ld0", ld, 1);
      chk("lit_data0", data, 8'h18);
      chk("lit_cs_rise", cs, 1);
    end
    if (stage == 1 && vcnt == 0 && hcnt == 0) chk("lit_attr0", attr, 8'h1E);
    if (stage == 1 && vcnt == 0 && hcnt == 639) chk("lit_cs_639", cs, 1);
    if (stage == 1 && vcnt == 0 && hcnt == 640) chk("lit_cs_640", cs, 0);
    if (stage == 1 && vcnt == 0 && hcnt == 700) chk("lit_ld_count", 16'(ld_cnt), 64);
    if (stage == 2 && vcnt == 15 && hcnt == 791) chk("lit_rowbase64", txt_addr, 64);
    if (stage == 2 && vcnt == 14 && hcnt == 49) chk("lit_cur_noblink", data, 8'h00);
    if (stage == 3 && vcnt == 13 && hcnt == 49) chk("lit_cur_row13", data, 8'h3C);
    if (stage == 3 && vcnt == 14 && hcnt == 49) chk("lit_cur_hit14", data, 8'hFF);
    if (stage == 3 && vcnt == 15 && hcnt == 49) chk("lit_cur_hit15", data, 8'hFF);
    if (stage == 6 && vcnt == 14 && hcnt == 49) chk("lit_cur_blinkoff", data, 8'h00);
    if (stage == 4 && vcnt == 20 && hcnt == 301)
      chk("lit_rst_zero", {3'b0, txt_addr | 11'(font_addr) | 11'(data) | 11'(attr), ld, cs}, 0);
    if (stage == 4 && vcnt == 20 && hcnt == 799) chk("lit_rst_resume", ld, 1);
    if (stage == 5 && vcnt == 479 && hcnt == 9) chk("lit_last_line", ld, 1);
    if (stage == 5 && vcnt == 0 && hcnt == 0) chk("lit_blank_quiet", 16'(ib_cnt), 0);
    if (stage == 5 && vcnt == 524 && hcnt == 799) chk("lit_resume_line0", ld, 1);
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic adv(input int n);
    repeat (n) begin
      tick();
      if (hcnt == 799) begin
        hcnt = 0;
        vcnt = (vcnt == 524) ? 10'd0 : vcnt + 10'd1;
      end else hcnt++;
    end
  endtask
  task automatic go(input int h, input int v);
    tick();
    hcnt = 11'(h);
    vcnt = 10'(v);
  endtask
  task automatic run_to(input int h, input int v);
    while (!(hcnt == 11'(h) && vcnt == 10'(v))) adv(1);
  endtask
  task automatic blink_burst();
    go(799, 524);
    repeat (15) tick();
    go(700, 12);
  endtask
  initial begin
    foreach (txt_mem[i]) txt_mem[i] = 16'($urandom);
    foreach (font_mem[i]) font_mem[i] = 8'($urandom);
    txt_mem[0] = 16'h1E41;
    font_mem[{8'h41, 4'd0}] = 8'h18;
    txt_mem[5] = 16'h0742;
    font_mem[{8'h42, 4'd13}] = 8'h3C;
    font_mem[{8'h42, 4'd14}] = 8'h00;
    font_mem[{8'h42, 4'd15}] = 8'h00;
    stage = 1;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    run_to(720, 0);
    stage = 2;
    cur_addr = 5;
    cur_en = 1;
    go(700, 12);
    run_to(720, 15);
    blink_burst();
    stage = 3;
    run_to(720, 15);
    blink_burst();
    stage = 6;
    run_to(720, 14);
    stage = 4;
    cur_en = 1'($urandom);
    run_to(300, 20);
    rst = 1;
    adv(1);
    rst = 0;
    run_to(720, 21);
    stage = 5;
    cur_addr = 2000;
    cur_en = 1;
    go(700, 478);
    run_to(720, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
